// File: rtl/multicycle_control_unit.sv
// Multicycle controller for the accumulator CPU: FETCH/EXEC/WAIT sequencing, program counter and opcode decode.
// Optional feature macro CU_BRANCH_EN enables BEQ/BNE/JMP; without it those opcodes decode as illegal NOPs.
module multicycle_control_unit #(
    parameter int NB_ADDR       = 11,
    parameter int NB_OPCODE     = 5,
    parameter int NB_SELECTOR_A = 2,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [NB_OPCODE-1:0]     i_opcode,
    input  logic [NB_ADDR-1:0]       i_operand,
    input  logic                     i_acc_zero,
    output logic [NB_ADDR-1:0]       o_address,
    output logic [NB_SELECTOR_A-1:0] o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_enb_acc,
    output logic                     o_operation,
    output logic                     o_wr_enb_ram,
    output logic                     o_rd_enb_ram,
    output logic                     o_busy,
    output logic                     o_halted,
    output logic                     o_illegal
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
`ifdef CU_BRANCH_EN
    localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(8);
    localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(9);
    localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(10);
`endif

    localparam logic [NB_SELECTOR_A-1:0] SEL_RAM = NB_SELECTOR_A'(0);
    localparam logic [NB_SELECTOR_A-1:0] SEL_IMM = NB_SELECTOR_A'(1);
    localparam logic [NB_SELECTOR_A-1:0] SEL_ALU = NB_SELECTOR_A'(2);

    localparam bit         HAS_WAIT  = (RD_LATENCY > 0);
    localparam logic [2:0] WAIT_LOAD = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t                     state_q, state_d;
    logic [NB_ADDR-1:0]         pc_q, pc_d;
    logic [2:0]                 wait_cnt_q, wait_cnt_d;
    logic [NB_SELECTOR_A-1:0]   sel_a_q, sel_a_d;
    logic                       sel_b_q, sel_b_d;
    logic                       sub_q, sub_d;

    logic                       dec_rd;
    logic                       dec_wr;
    logic                       dec_acc;
    logic                       dec_halt;
    logic                       dec_illegal;
    logic [NB_SELECTOR_A-1:0]   dec_sel_a;
    logic                       dec_sel_b;
    logic                       dec_sub;

    logic [NB_ADDR-1:0]         pc_inc;
    logic [NB_ADDR-1:0]         exec_target;
    logic                       in_exec;
    logic                       in_wait;
    logic                       last_wait;

`ifdef CU_BRANCH_EN
    logic                       br_taken;
`else
    logic                       unused_branch_inputs;
    assign unused_branch_inputs = ^{i_acc_zero, i_operand};
`endif

    always_comb begin
        dec_rd      = 1'b0;
        dec_wr      = 1'b0;
        dec_acc     = 1'b0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        dec_sel_a   = SEL_RAM;
        dec_sel_b   = 1'b0;
        dec_sub     = 1'b0;
`ifdef CU_BRANCH_EN
        br_taken    = 1'b0;
`endif
        case (i_opcode)
            OP_HLT:  dec_halt = 1'b1;
            OP_STO:  dec_wr = 1'b1;
            OP_LD: begin
                dec_rd    = 1'b1;
                dec_acc   = 1'b1;
                dec_sel_a = SEL_RAM;
            end
            OP_LDI: begin
                dec_acc   = 1'b1;
                dec_sel_a = SEL_IMM;
            end
            OP_ADD: begin
                dec_rd    = 1'b1;
                dec_acc   = 1'b1;
                dec_sel_a = SEL_ALU;
            end
            OP_ADDI: begin
                dec_acc   = 1'b1;
                dec_sel_a = SEL_ALU;
                dec_sel_b = 1'b1;
            end
            OP_SUB: begin
                dec_rd    = 1'b1;
                dec_acc   = 1'b1;
                dec_sel_a = SEL_ALU;
                dec_sub   = 1'b1;
            end
            OP_SUBI: begin
                dec_acc   = 1'b1;
                dec_sel_a = SEL_ALU;
                dec_sel_b = 1'b1;
                dec_sub   = 1'b1;
            end
`ifdef CU_BRANCH_EN
            OP_BEQ:  br_taken = i_acc_zero;
            OP_BNE:  br_taken = !i_acc_zero;
            OP_JMP:  br_taken = 1'b1;
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

    assign pc_inc = pc_q + NB_ADDR'(1);
`ifdef CU_BRANCH_EN
    assign exec_target = br_taken ? i_operand : pc_inc;
`else
    assign exec_target = pc_inc;
`endif

    // The PC only moves on the final cycle of an instruction; RAM reads defer it to the last WAIT cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        sub_d      = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                sel_a_d = dec_sel_a;
                sel_b_d = dec_sel_b;
                sub_d   = dec_sub;
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else if (dec_rd && HAS_WAIT) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = exec_target;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            wait_cnt_q <= 3'd0;
            sel_a_q    <= SEL_RAM;
            sel_b_q    <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_cnt_q <= wait_cnt_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            sub_q      <= sub_d;
        end
    end

    assign in_exec   = (state_q == ST_EXEC);
    assign in_wait   = (state_q == ST_WAIT);
    assign last_wait = in_wait && (wait_cnt_q == 3'd0);

    // Operand selects come straight from decode in EXEC and from the captured copy while waiting on RAM.
    assign o_address    = pc_q;
    assign o_busy       = (state_q == ST_FETCH) || in_exec || in_wait;
    assign o_halted     = (state_q == ST_HALT);
    assign o_rd_enb_ram = in_exec && dec_rd;
    assign o_wr_enb_ram = in_exec && dec_wr;
    assign o_illegal    = in_exec && dec_illegal;
    assign o_enb_acc    = (in_exec && dec_acc && !(dec_rd && HAS_WAIT)) || last_wait;
    assign o_sel_a      = in_exec ? dec_sel_a : (in_wait ? sel_a_q : SEL_RAM);
    assign o_sel_b      = in_exec ? dec_sel_b : (in_wait && sel_b_q);
    assign o_operation  = in_exec ? dec_sub : (in_wait && sub_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: a program ROM drives the main instance (RD_LATENCY = 3)
// against an instruction-level model; a second instance (RD_LATENCY = 0) checks the zero-latency read path.
module tb_multicycle_control_unit;

    localparam int NB_ADDR   = 11;
    localparam int LAT       = 3;
    localparam int ROM_DEPTH = 1 << NB_ADDR;

    typedef struct {
        bit         rd;
        bit         wr;
        bit         acc;
        bit         halt;
        bit         ill;
        bit         is_branch;
        logic [1:0] sa;
        bit         sb;
        bit         sub;
    } sem_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    logic               start;
    logic [4:0]         opcode;
    logic [10:0]        operand;
    logic               acc_zero;
    logic [10:0]        address;
    logic [1:0]         sel_a;
    logic               sel_b, enb_acc, operation, wr_enb, rd_enb, busy, halted, illegal;
    logic [9:0]         obs_ctl;

    logic               start0;
    logic [4:0]         opcode0;
    logic [10:0]        operand0;
    logic [10:0]        address0;
    logic [1:0]         sel_a0;
    logic               sel_b0, enb_acc0, operation0, wr_enb0, rd_enb0, busy0, halted0, illegal0;
    logic [9:0]         obs_ctl0;

    logic [4:0]         rom_op   [ROM_DEPTH];
    logic [10:0]        rom_opnd [ROM_DEPTH];
    logic [10:0]        m_pc;

    int vector_count = 0;
    int miss_count   = 0;

    always #5 clock = ~clock;

    multicycle_control_unit #(.NB_ADDR(11), .NB_OPCODE(5), .NB_SELECTOR_A(2), .RD_LATENCY(LAT)) dut (
        .i_clock(clock), .i_reset(reset_n), .i_start(start), .i_opcode(opcode),
        .i_operand(operand), .i_acc_zero(acc_zero), .o_address(address), .o_sel_a(sel_a),
        .o_sel_b(sel_b), .o_enb_acc(enb_acc), .o_operation(operation), .o_wr_enb_ram(wr_enb),
        .o_rd_enb_ram(rd_enb), .o_busy(busy), .o_halted(halted), .o_illegal(illegal)
    );

    multicycle_control_unit #(.NB_ADDR(11), .NB_OPCODE(5), .NB_SELECTOR_A(2), .RD_LATENCY(0)) dut0 (
        .i_clock(clock), .i_reset(reset_n), .i_start(start0), .i_opcode(opcode0),
        .i_operand(operand0), .i_acc_zero(1'b0), .o_address(address0), .o_sel_a(sel_a0),
        .o_sel_b(sel_b0), .o_enb_acc(enb_acc0), .o_operation(operation0), .o_wr_enb_ram(wr_enb0),
        .o_rd_enb_ram(rd_enb0), .o_busy(busy0), .o_halted(halted0), .o_illegal(illegal0)
    );

    assign obs_ctl  = {sel_a, sel_b, enb_acc, operation, wr_enb, rd_enb, busy, halted, illegal};
    assign obs_ctl0 = {sel_a0, sel_b0, enb_acc0, operation0, wr_enb0, rd_enb0, busy0, halted0, illegal0};

    function automatic logic [9:0] pack_ctl(input logic [1:0] sa, input logic sb, input logic enb,
                                            input logic sub, input logic wr, input logic rd,
                                            input logic bsy, input logic hlt, input logic ill);
        return {sa, sb, enb, sub, wr, rd, bsy, hlt, ill};
    endfunction

    // Instruction-set meaning of each opcode, independent of how the controller sequences it.
    function automatic sem_t semantics(input logic [4:0] op);
        sem_t s;
        s = '{default: 0};
        case (op)
            5'd0:  s.halt = 1;
            5'd1:  s.wr = 1;
            5'd2:  begin s.rd = 1; s.acc = 1; s.sa = 2'b00; end
            5'd3:  begin s.acc = 1; s.sa = 2'b01; end
            5'd4:  begin s.rd = 1; s.acc = 1; s.sa = 2'b10; end
            5'd5:  begin s.acc = 1; s.sa = 2'b10; s.sb = 1; end
            5'd6:  begin s.rd = 1; s.acc = 1; s.sa = 2'b10; s.sub = 1; end
            5'd7:  begin s.acc = 1; s.sa = 2'b10; s.sb = 1; s.sub = 1; end
`ifdef CU_BRANCH_EN
            5'd8, 5'd9, 5'd10: s.is_branch = 1;
`endif
            default: s.ill = 1;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] exec_ctl(input sem_t s, input int lat);
        return pack_ctl(s.sa, s.sb, s.acc && !(s.rd && lat > 0), s.sub, s.wr, s.rd, 1'b1, 1'b0, s.ill);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic az, input logic [10:0] rom_addr);
        start    = st;
        acc_zero = az;
        opcode   = rom_op[rom_addr];
        operand  = rom_opnd[rom_addr];
    endtask

    task automatic doCycle(input string tag, input logic st, input logic az,
                           input logic [10:0] exp_addr, input logic [9:0] exp_ctl);
        applyStimulus(st, az, m_pc);
        @(negedge clock);
        checkOutput($sformatf("%s/addr@%0h", tag, m_pc), {21'd0, address}, {21'd0, exp_addr});
        checkOutput($sformatf("%s/ctl@%0h", tag, m_pc), {22'd0, obs_ctl}, {22'd0, exp_ctl});
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction at the model PC and leaves the controller about to FETCH the next one.
    task automatic runInstr(input string tag);
        sem_t        s;
        logic [4:0]  op;
        logic        az;
        logic [10:0] next_pc;
        int          n;
        op = rom_op[m_pc];
        s  = semantics(op);
        doCycle({tag, "/fetch"}, 1'($urandom), 1'($urandom), m_pc,
                pack_ctl(2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
        az = 1'($urandom);
        doCycle({tag, "/exec"}, 1'($urandom), az, m_pc, exec_ctl(s, LAT));
        if (s.halt) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++)
                doCycle({tag, "/halt"}, 1'b0, 1'($urandom), m_pc, pack_ctl(2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
            doCycle({tag, "/halt_start"}, 1'b1, 1'($urandom), m_pc, pack_ctl(2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
            m_pc = '0;
            return;
        end
        if (s.rd && LAT > 0) begin
            for (int i = 1; i <= LAT; i++)
                doCycle({tag, "/wait"}, 1'($urandom), 1'($urandom), m_pc,
                        pack_ctl(s.sa, s.sb, i == LAT, s.sub, 0, 0, 1, 0, 0));
        end
        next_pc = m_pc + 11'd1;
        if (s.is_branch) begin
            if ((op == 5'd8 && az) || (op == 5'd9 && !az) || op == 5'd10)
                next_pc = rom_opnd[m_pc];
        end
        m_pc = next_pc;
    endtask

    initial begin
        int          pick;
        logic [4:0]  op0;
        logic [10:0] p0;
        sem_t        s0;

        start = 0; acc_zero = 0; opcode = 0; operand = 0;
        start0 = 0; opcode0 = 0; operand0 = 0;
        m_pc = '0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom_op[i]   = 5'd31;
            rom_opnd[i] = 11'(i);
        end
        rom_op[0] = 5'd3; rom_opnd[0] = 11'd5;
        rom_op[1] = 5'd5; rom_opnd[1] = 11'd3;
        rom_op[2] = 5'd1; rom_opnd[2] = 11'd7;
        rom_op[3] = 5'd0; rom_opnd[3] = 11'd0;

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("reset/addr", {21'd0, address}, 32'd0);
        checkOutput("reset/ctl", {22'd0, obs_ctl}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        doCycle("idle", 1'b0, 1'b0, 11'd0, 10'd0);
        doCycle("idle", 1'b0, 1'b1, 11'd0, 10'd0);
        doCycle("idle_start", 1'b1, 1'b0, 11'd0, 10'd0);

        for (int i = 0; i < 4; i++) runInstr("prog");

        // Straight-line program across the whole ROM so the PC wraps through an illegal opcode at 0x7FF.
        for (int i = 0; i < ROM_DEPTH; i++) begin
            pick        = $urandom_range(0, 9);
            rom_op[i]   = (pick < 7) ? 5'(pick + 1) : 5'($urandom_range(11, 31));
            rom_opnd[i] = 11'($urandom);
        end
        rom_op[ROM_DEPTH-1] = 5'd31;
        for (int i = 0; i < ROM_DEPTH + 1; i++) runInstr("wrap");

        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom_op[i]   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 10));
            rom_opnd[i] = 11'($urandom);
        end
        for (int i = 0; i < 400; i++) runInstr("rand");

        rom_op[m_pc] = 5'd2;
        s0 = semantics(5'd2);
        doCycle("rstwait/fetch", 1'b0, 1'b0, m_pc, pack_ctl(2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
        doCycle("rstwait/exec", 1'b0, 1'b0, m_pc, exec_ctl(s0, LAT));
        doCycle("rstwait/wait", 1'b0, 1'b0, m_pc, pack_ctl(2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstwait/addr", {21'd0, address}, 32'd0);
        checkOutput("rstwait/ctl", {22'd0, obs_ctl}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        m_pc = '0;
        for (int i = 0; i < 3; i++) doCycle("post_rst", 1'b0, 1'($urandom), 11'd0, 10'd0);

        p0 = '0;
        start0 = 1'b1;
        @(posedge clock);
        #1 start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            op0 = 5'($urandom_range(1, 7));
            s0  = semantics(op0);
            @(negedge clock);
            checkOutput("lat0/fetch_addr", {21'd0, address0}, {21'd0, p0});
            checkOutput("lat0/fetch_ctl", {22'd0, obs_ctl0}, {22'd0, pack_ctl(2'b00, 0, 0, 0, 0, 0, 1, 0, 0)});
            @(posedge clock);
            #1;
            opcode0  = op0;
            operand0 = 11'($urandom);
            @(negedge clock);
            checkOutput($sformatf("lat0/exec_ctl op%0d", op0), {22'd0, obs_ctl0}, {22'd0, exec_ctl(s0, 0)});
            @(posedge clock);
            #1;
            p0 = p0 + 11'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle controller for the accumulator processor. It sequences FETCH/EXECUTE through a state machine, holds the program counter, and decodes the 5-bit opcode into datapath and RAM controls. It adds start/halt handshaking, configurable RAM read latency, and conditional/unconditional branches. It sits between the program ROM (address out, opcode and operand in) and the datapath/data RAM.

## Interface
- NB_ADDR, 11, program counter and operand width
- NB_OPCODE, 5, opcode width
- NB_SELECTOR_A, 2, accumulator input selector width
- RD_LATENCY, 1, data RAM read latency in cycles, legal 0..7
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  start request, sampled in IDLE and HALT only
- i_opcode  in  NB_OPCODE  opcode from ROM, valid in EXEC
- i_operand  in  NB_ADDR  operand/branch target from ROM, valid in EXEC
- i_acc_zero  in  1  accumulator == 0 flag from datapath
- o_address  out  NB_ADDR  ROM address (PC)
- o_sel_a  out  NB_SELECTOR_A  accumulator source: 00 RAM, 01 immediate, 10 ALU
- o_sel_b  out  1  ALU operand B: 0 RAM, 1 immediate
- o_enb_acc  out  1  accumulator load strobe
- o_operation  out  1  ALU op: 0 add, 1 subtract
- o_wr_enb_ram  out  1  RAM write strobe
- o_rd_enb_ram  out  1  RAM read strobe
- o_busy  out  1  high in FETCH, EXEC, WAIT
- o_halted  out  1  high in HALT
- o_illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: IDLE, FETCH, EXEC, WAIT, HALT. Reset enters IDLE with PC = 0.
- IDLE: if i_start = 1, go to FETCH; otherwise stay.
- FETCH: o_address = PC. The ROM is synchronous. Always go to EXEC.
- EXEC: decode i_opcode.
  - HLT 00000 -> HALT.
  - STO 00001: o_wr_enb_ram.
  - LD 00010: rd, sel_a = 00, enb_acc.
  - LDI 00011: sel_a = 01, enb_acc.
  - ADD 00100: rd, sel_a = 10, sel_b = 0, op = 0, enb_acc.
  - ADDI 00101: sel_a = 10, sel_b = 1, op = 0, enb_acc.
  - SUB 00110: rd, sel_a = 10, sel_b = 0, op = 1, enb_acc.
  - SUBI 00111: sel_a = 10, sel_b = 1, op = 1, enb_acc.
  - BEQ 01000: PC <= i_operand if i_acc_zero, else PC + 1.
  - BNE 01001: PC <= i_operand if !i_acc_zero, else PC + 1.
  - JMP 01010: PC <= i_operand.
  - Any other opcode: NOP with PC + 1, and o_illegal pulses for the EXEC cycle.
- RAM-read opcodes (LD/ADD/SUB) with RD_LATENCY > 0: go to WAIT. A down-counter is loaded with RD_LATENCY-1 and WAIT exits to FETCH at 0.
- All other opcodes, and RAM-read opcodes with RD_LATENCY = 0, go from EXEC to FETCH.
- HALT: PC frozen and all strobes 0. i_start = 1 clears PC to 0 and goes to FETCH.
- PC arithmetic is modulo 2^NB_ADDR: PC = 2^NB_ADDR-1 increments to 0.
- PC updates only on the final cycle of an instruction (EXEC, or the last WAIT cycle).

## Timing
- Reset values: o_address = 0; o_sel_a = 00; o_busy = 0; o_halted = 0. All other outputs are 0.
- Reset applies immediately regardless of state, including mid-WAIT. The FSM resumes in IDLE after reset releases.
- Cycles per instruction:
  - immediate, store, branch and NOP: 2 (FETCH + EXEC);
  - RAM-read: 2 + RD_LATENCY.
- o_rd_enb_ram and o_wr_enb_ram are one-cycle pulses in EXEC.
- o_sel_a, o_sel_b and o_operation hold their decoded values from EXEC through the last WAIT cycle.
- o_enb_acc is a one-cycle pulse:
  - in EXEC for immediates, and for RAM reads when RD_LATENCY = 0;
  - in the last WAIT cycle for RAM reads when RD_LATENCY > 0.
- All decode outputs are 0 in IDLE, FETCH and HALT.
- i_start is ignored in FETCH, EXEC and WAIT.
- i_acc_zero is sampled in EXEC only.
- HALT is entered on the cycle after the EXEC of HLT. o_halted rises on that same edge.

## Configuration
- CU_BRANCH_EN defined: BEQ, BNE and JMP operate as described.
- CU_BRANCH_EN undefined:
  - opcodes 01000–01010 decode as illegal NOPs (PC + 1, o_illegal pulse);
  - i_acc_zero is unused;
  - no branch mux is synthesised.

## Test plan
- Reset low mid-WAIT (RD_LATENCY = 3) -> all outputs 0 and IDLE immediately. After release with i_start = 0 -> o_address stays 0 and o_busy = 0.
- Program LDI 5, ADDI 3, STO 7, HLT -> enb_acc pulses in cycles 2 and 4, with sel_a = 01 then 10 and sel_b = 1. wr_enb_ram pulses in cycle 6. o_halted = 1 after cycle 8 with PC = 3.
- LD 4 with RD_LATENCY = 2 -> rd_enb_ram in EXEC, enb_acc two cycles later with sel_a = 00, next FETCH at PC = 1. Total 4 cycles.
- With CU_BRANCH_EN:
  - BEQ 0x100 with i_acc_zero = 1 -> next o_address = 0x100;
  - BNE 0x100 with i_acc_zero = 1 -> next o_address = PC + 1;
  - JMP 0 at PC = 0x7FF -> o_address = 0.
- Opcode 11111 at PC = 0x7FF -> o_illegal pulses once and PC wraps to 0x000. Without CU_BRANCH_EN, JMP 0x010 -> o_illegal pulses and PC + 1.
- In HALT, pulse i_start -> PC = 0 and FETCH next cycle. In FETCH, i_start = 1 -> no effect.
